qrd_feed_scheduler: RTL and testbench

Row-launch scheduler for the 4x4 QRD-RLS systolic array. It accepts input rows over a valid/ready handshake and launches them into the array at a fixed minimum interval. Each row is tagged as initialisation (first N rows) or update. The scheduler tracks every in-flight row through the array's fixed pipeline latency and flags each result as it emerges. It sits between the sample source and the array front end; the skew delay lines inside the array are driven from its launch outputs.

---
 rtl/qrd_feed_scheduler.sv | 162 ++++++++++++++++
 tb/tb_qrd_feed_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qrd_feed_scheduler.sv
// qrd_feed_scheduler: paced row launcher and in-flight tracker for the QRD-RLS array.
// Define QRD_SCHED_STATS_EN to add the stall_cnt statistics output.
module qrd_feed_scheduler #(
  parameter int N           = 4,
  parameter int DATA_LENGTH = 8,
  parameter int SKEW        = 22,
  parameter int II          = 2,
  parameter int LATENCY     = N * SKEW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [15:0]              frame_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*DATA_LENGTH-1:0] in_row,
  output logic                     arr_launch,
  output logic [N*DATA_LENGTH-1:0] arr_row,
  output logic                     arr_init,
  output logic                     res_valid,
  output logic [15:0]              res_idx,
  output logic                     busy,
  output logic                     done
`ifdef QRD_SCHED_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int W  = N * DATA_LENGTH;
  localparam int GW = (II > 1) ? $clog2(II) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(II - 1);
  localparam logic [15:0]   NIDX    = 16'(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        launched_q, launched_d;
  logic [15:0]        res_idx_q, res_idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               launch_q, launch_d;
  logic               init_q, init_d;
  logic [W-1:0]       row_q, row_d;
  logic [LATENCY-1:0] trk_q, trk_d;
  logic               accept;
  logic [15:0]        res_next;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q == S_RUN) && (gap_q >= GAP_MAX)
                 && (launched_q < len_q);
  assign accept    = in_valid && in_ready;
  assign res_valid = trk_q[LATENCY-1];
  assign res_next  = res_idx_q + {15'd0, res_valid};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    launched_d = launched_q;
    res_idx_d  = res_next;
    gap_d      = gap_q;
    launch_d   = accept;
    init_d     = init_q;
    row_d      = row_q;
    trk_d      = {trk_q[LATENCY-2:0], launch_q};

    if (accept) begin
      launched_d = launched_q + 16'd1;
      gap_d      = '0;
      row_d      = in_row;
      init_d     = (launched_q < NIDX);
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = frame_len;
          launched_d = '0;
          res_idx_d  = '0;
          gap_d      = GAP_MAX;
          state_d    = (frame_len == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (launched_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_next == len_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards everything in flight, including a same-cycle start.
    if (abort) begin
      state_d    = S_IDLE;
      len_d      = '0;
      launched_d = '0;
      res_idx_d  = '0;
      gap_d      = '0;
      launch_d   = 1'b0;
      trk_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      launched_q <= '0;
      res_idx_q  <= '0;
      gap_q      <= '0;
      launch_q   <= 1'b0;
      init_q     <= 1'b0;
      row_q      <= '0;
      trk_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      launched_q <= launched_d;
      res_idx_q  <= res_idx_d;
      gap_q      <= gap_d;
      launch_q   <= launch_d;
      init_q     <= init_d;
      row_q      <= row_d;
      trk_q      <= trk_d;
    end
  end

  assign arr_launch = launch_q;
  assign arr_row    = row_q;
  assign arr_init   = init_q;
  assign res_idx    = res_idx_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

`ifdef QRD_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_ready && !in_valid && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    if (abort || ((state_q == S_IDLE) && start && (frame_len != 16'd0)))
      stall_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_qrd_feed_scheduler.sv
// tb_qrd_feed_scheduler: directed frames with a queue-based scoreboard.
// A negedge monitor pops expected launches, results and done pulses.
module tb_qrd_feed_scheduler;
  localparam int N  = 4;
  localparam int DL = 8;
  localparam int W  = N * DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   frame_len = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_row = '0;
  logic          in_ready, arr_launch, arr_init, res_valid, busy, done;
  logic [W-1:0]  arr_row;
  logic [15:0]   res_idx;
`ifdef QRD_SCHED_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic        flag;
  } exp_t;

  exp_t lq[$];
  exp_t rq[$];
  exp_t dq[$];
  exp_t le, re, de;

  qrd_feed_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_len(frame_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .arr_launch(arr_launch), .arr_row(arr_row),
    .arr_init(arr_init), .res_valid(res_valid), .res_idx(res_idx),
    .busy(busy), .done(done)
`ifdef QRD_SCHED_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [31:0] v,
                              input logic f);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.flag = f;
    return e;
  endfunction

  function automatic logic [31:0] row(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0013_1F07;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (arr_launch) begin
        if (lq.size() == 0) chk("spurious_launch", arr_launch, 0);
        else begin
          le = lq.pop_front();
          chk("launch_cyc", cyc, le.cyc);
          chk("arr_row", arr_row, le.val);
          chk("arr_init", arr_init, le.flag);
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) chk("spurious_res", res_valid, 0);
        else begin
          re = rq.pop_front();
          chk("res_cyc", cyc, re.cyc);
          chk("res_idx", res_idx, re.val);
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("spurious_done", done, 0);
        else begin
          de = dq.pop_front();
          chk("done_cyc", cyc, de.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic feed(input int n, input int period, input int phase,
                      input int base, input int limit);
    int k;
    k = 0;
    while (k < n && cyc < limit) begin
      in_valid = (((cyc - base) % period) == phase);
      in_row = row(k);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  initial begin
    int s;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_arr_launch", arr_launch, 0);
    chk("rst_arr_row", arr_row, 0);
    chk("rst_arr_init", arr_init, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // basic frame, in_valid held high
    s = cyc;
    start = 1'b1;
    frame_len = 16'd6;
    for (int j = 0; j < 6; j++) begin
      lq.push_back(mk(s + 2 + 2 * j, row(j), j < 4));
      rq.push_back(mk(s + 90 + 2 * j, 32'(j), 1'b0));
    end
    dq.push_back(mk(s + 101, 0, 1'b0));
    feed(6, 1, 0, s, s + 40);
    wait_to(s + 101);
    chk("basic_busy_done", busy, 1);
    tick();
    chk("basic_busy_low", busy, 0);

    // back-pressure, one valid pulse every 5 cycles
    s = cyc;
    start = 1'b1;
    frame_len = 16'd3;
    for (int j = 0; j < 3; j++) begin
      lq.push_back(mk(s + 4 + 5 * j, row(j), 1'b1));
      rq.push_back(mk(s + 92 + 5 * j, 32'(j), 1'b0));
    end
    dq.push_back(mk(s + 103, 0, 1'b0));
    feed(3, 5, 3, s, s + 40);
`ifdef QRD_SCHED_STATS_EN
    wait_to(s + 20);
    chk("stall_cnt", stall_cnt, 8);
`endif
    wait_to(s + 104);
    chk("bp_busy", busy, 0);

    // zero-length frame
    s = cyc;
    start = 1'b1;
    frame_len = 16'd0;
    dq.push_back(mk(s + 1, 0, 1'b0));
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1);
    wait_to(s + 3);
    chk("zero_idle", busy, 0);

    // reset asserted mid-frame with rows in flight
    s = cyc;
    start = 1'b1;
    frame_len = 16'd4;
    for (int j = 0; j < 4; j++)
      lq.push_back(mk(s + 2 + 2 * j, row(j), 1'b1));
    feed(4, 1, 0, s, s + 40);
    wait_to(s + 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_arr_launch", arr_launch, 0);
    chk("mid_rst_arr_row", arr_row, 0);
    chk("mid_rst_arr_init", arr_init, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_idx", res_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    lq.delete();
    rq.delete();
    dq.delete();
    tick();
    rst_n = 1'b1;
    wait_to(cyc + 100);

    // abort with rows in flight
    s = cyc;
    start = 1'b1;
    frame_len = 16'd4;
    for (int j = 0; j < 4; j++)
      lq.push_back(mk(s + 2 + 2 * j, row(j), 1'b1));
    feed(4, 1, 0, s, s + 40);
    wait_to(s + 12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    wait_to(s + 112);

    // single-row frame after abort
    s = cyc;
    start = 1'b1;
    frame_len = 16'd1;
    lq.push_back(mk(s + 2, row(0), 1'b1));
    rq.push_back(mk(s + 90, 0, 1'b0));
    dq.push_back(mk(s + 91, 0, 1'b0));
    feed(1, 1, 0, s, s + 20);
    wait_to(s + 92);
    chk("one_busy", busy, 0);

    // start and abort together in idle
    s = cyc;
    start = 1'b1;
    abort = 1'b1;
    frame_len = 16'd3;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_in_ready", in_ready, 0);
    wait_to(s + 6);
    in_valid = 1'b0;
    chk("sa_busy_later", busy, 0);

    // start pulsed during drain is ignored
    s = cyc;
    start = 1'b1;
    frame_len = 16'd2;
    for (int j = 0; j < 2; j++) begin
      lq.push_back(mk(s + 2 + 2 * j, row(j), 1'b1));
      rq.push_back(mk(s + 90 + 2 * j, 32'(j), 1'b0));
    end
    dq.push_back(mk(s + 93, 0, 1'b0));
    feed(2, 1, 0, s, s + 20);
    wait_to(s + 40);
    start = 1'b1;
    frame_len = 16'd5;
    tick();
    start = 1'b0;
    chk("drain_in_ready", in_ready, 0);
    wait_to(s + 94);
    chk("drain_busy", busy, 0);
    wait_to(s + 110);

    chk("launch_left", lq.size(), 0);
    chk("res_left", rq.size(), 0);
    chk("done_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
